// File: rtl/multi_byte_rx.sv
// Assembles consecutive UART bytes into one DATA_WIDTH-bit word and pulses on completion.
// A gap longer than TIMEOUT_CYCLES inside a frame discards the partial word.
module multi_byte_rx #(
  parameter int DATA_WIDTH     = 32,
  parameter int MSB_1st        = 1,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  rx_done,
  input  logic [7:0]            rx_data,
  output logic [DATA_WIDTH-1:0] multi_byte_data_out,
  output logic                  multi_byte_rx_done,
  output logic                  rx_timeout_err,
  output logic                  busy
);

  localparam int NBYTES = DATA_WIDTH / 8;
  localparam int CNT_W  = $clog2(NBYTES) + 1;
  localparam int TMO_W  = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NBYTES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [CNT_W-1:0]      byte_cnt;
  logic [TMO_W-1:0]      tmo_cnt;
  logic [DATA_WIDTH-1:0] shifted;

  // Word as it would look once the current rx_data is shifted in.
  always_comb begin
    shifted = (MSB_1st != 0) ? {shift_reg[DATA_WIDTH-9:0], rx_data}
                             : {rx_data, shift_reg[DATA_WIDTH-1:8]};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state               <= IDLE;
      shift_reg           <= '0;
      byte_cnt            <= '0;
      tmo_cnt             <= '0;
      multi_byte_data_out <= '0;
      multi_byte_rx_done  <= 1'b0;
      rx_timeout_err      <= 1'b0;
      busy                <= 1'b0;
    end else begin
      multi_byte_rx_done <= 1'b0;
      rx_timeout_err     <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_done) begin
            shift_reg <= shifted;
            byte_cnt  <= CNT_W'(1);
            tmo_cnt   <= '0;
            busy      <= 1'b1;
            state     <= COLLECT;
          end
        end
        COLLECT: begin
          // An arriving byte always wins over timeout expiry in the same cycle.
          if (rx_done) begin
            tmo_cnt   <= '0;
            shift_reg <= shifted;
            if (byte_cnt == LAST_BYTE) begin
              multi_byte_data_out <= shifted;
              multi_byte_rx_done  <= 1'b1;
              byte_cnt            <= '0;
              busy                <= 1'b0;
              state               <= IDLE;
            end else begin
              byte_cnt <= byte_cnt + CNT_W'(1);
            end
          end else if (tmo_cnt == TMO_LAST) begin
            rx_timeout_err <= 1'b1;
            shift_reg      <= '0;
            byte_cnt       <= '0;
            busy           <= 1'b0;
            state          <= IDLE;
          end else if (tmo_cnt != '1) begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_byte_rx.sv
// Self-checking bench for multi_byte_rx: MSB-first and LSB-first instances share stimulus
// and are compared every cycle against a queue-based frame model.
module tb_multi_byte_rx;

  localparam int DW  = 32;
  localparam int TMO = 50;

  logic          clk = 1'b0;
  logic          rstn;
  logic          rx_done;
  logic [7:0]    rx_data;
  logic [DW-1:0] data_m, data_l;
  logic          done_m, done_l, err_m, err_l, busy_m, busy_l;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  logic [7:0]    byte_q[$];
  int            gap;
  logic [DW-1:0] exp_m, exp_l;
  logic          exp_done, exp_err, exp_busy;

  typedef struct {
    logic [0:3][7:0] bytes;
    logic [DW-1:0]   word_msb;
    logic [DW-1:0]   word_lsb;
  } frame_t;

  frame_t table_v[3];

  multi_byte_rx #(.DATA_WIDTH(DW), .MSB_1st(1), .TIMEOUT_CYCLES(TMO)) dut_msb (
    .clk(clk), .rstn(rstn), .rx_done(rx_done), .rx_data(rx_data),
    .multi_byte_data_out(data_m), .multi_byte_rx_done(done_m),
    .rx_timeout_err(err_m), .busy(busy_m)
  );

  multi_byte_rx #(.DATA_WIDTH(DW), .MSB_1st(0), .TIMEOUT_CYCLES(TMO)) dut_lsb (
    .clk(clk), .rstn(rstn), .rx_done(rx_done), .rx_data(rx_data),
    .multi_byte_data_out(data_l), .multi_byte_rx_done(done_l),
    .rx_timeout_err(err_l), .busy(busy_l)
  );

  always #5 clk = ~clk;

  task automatic modelReset();
    byte_q.delete();
    gap      = 0;
    exp_m    = '0;
    exp_l    = '0;
    exp_done = 1'b0;
    exp_err  = 1'b0;
    exp_busy = 1'b0;
  endtask

  // Frame-level model: bytes accumulate in a queue, the word is built arithmetically.
  task automatic modelStep(input logic d, input logic [7:0] x);
    exp_done = 1'b0;
    exp_err  = 1'b0;
    if (d) begin
      byte_q.push_back(x);
      gap = 0;
      if (byte_q.size() == DW / 8) begin
        exp_m = '0;
        exp_l = '0;
        for (int i = 0; i < DW / 8; i++) begin
          exp_m = (exp_m << 8) | DW'(byte_q[i]);
          exp_l = exp_l | (DW'(byte_q[i]) << (8 * i));
        end
        byte_q.delete();
        exp_done = 1'b1;
      end
    end else if (byte_q.size() > 0) begin
      gap++;
      if (gap >= TMO) begin
        byte_q.delete();
        exp_err = 1'b1;
      end
    end
    exp_busy = (byte_q.size() > 0);
  endtask

  task automatic checkOutput(input string name);
    vectors++;
    if (data_m !== exp_m || done_m !== exp_done || err_m !== exp_err || busy_m !== exp_busy ||
        data_l !== exp_l || done_l !== exp_done || err_l !== exp_err || busy_l !== exp_busy) begin
      miscompares++;
      $display("[TB] FAIL %s t=%0t: got msb{d=%h done=%b err=%b busy=%b} lsb{d=%h done=%b err=%b busy=%b} want msb d=%h lsb d=%h done=%b err=%b busy=%b",
               name, $time, data_m, done_m, err_m, busy_m, data_l, done_l, err_l, busy_l,
               exp_m, exp_l, exp_done, exp_err, exp_busy);
    end
  endtask

  task automatic checkValue(input string name, input logic [DW-1:0] actual, input logic [DW-1:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s t=%0t: got %h want %h", name, $time, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic d, input logic [7:0] x);
    rx_done = d;
    rx_data = x;
    @(posedge clk);
    modelStep(d, x);
    #1;
    checkOutput("cycle");
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00);
  endtask

  // Sends one byte followed by the standard 10-cycle spacing
  task automatic sendSpaced(input logic [7:0] x);
    applyStimulus(1'b1, x);
    idle(9);
  endtask

  task automatic doReset();
    rx_done = 1'b0;
    #2 rstn = 1'b0;
    modelReset();
    #1;
    checkOutput("reset_async");
    @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  initial begin
    int found;

    table_v[0] = '{bytes: {8'h12, 8'h34, 8'h56, 8'h78}, word_msb: 32'h12345678, word_lsb: 32'h78563412};
    table_v[1] = '{bytes: {8'hDE, 8'hAD, 8'hBE, 8'hEF}, word_msb: 32'hDEADBEEF, word_lsb: 32'hEFBEADDE};
    table_v[2] = '{bytes: {8'h00, 8'hFF, 8'h80, 8'h01}, word_msb: 32'h00FF8001, word_lsb: 32'h0180FF00};

    rstn    = 1'b0;
    rx_done = 1'b0;
    rx_data = 8'h00;
    modelReset();
    #12;
    checkOutput("reset_state");
    @(posedge clk);
    #1 rstn = 1'b1;
    idle(3);

    // Table-driven frames with constant expected words
    for (int f = 0; f < 3; f++) begin
      for (int b = 0; b < 3; b++) begin
        applyStimulus(1'b1, table_v[f].bytes[b]);
        checkValue("busy_during_frame", 32'(busy_m), 32'd1);
        idle(9);
      end
      applyStimulus(1'b1, table_v[f].bytes[3]);
      checkValue("frame_done_pulse", 32'(done_m), 32'd1);
      checkValue("frame_word_msb", data_m, table_v[f].word_msb);
      checkValue("frame_word_lsb", data_l, table_v[f].word_lsb);
      applyStimulus(1'b0, 8'h00);
      checkValue("done_one_cycle", 32'(done_m), 32'd0);
      idle(8);
    end

    // Timeout: two bytes then silence
    sendSpaced(8'hAA);
    applyStimulus(1'b1, 8'hBB);
    found = 0;
    for (int k = 1; k <= 60; k++) begin
      applyStimulus(1'b0, 8'h00);
      if (err_m) begin
        found = k;
        break;
      end
    end
    checkValue("timeout_delay", 32'(found), 32'd50);
    checkValue("timeout_keeps_data", data_m, 32'h00FF8001);
    sendSpaced(8'h01);
    sendSpaced(8'h02);
    sendSpaced(8'h03);
    applyStimulus(1'b1, 8'h04);
    checkValue("after_timeout_word", data_m, 32'h01020304);
    idle(5);

    // Byte arriving exactly in the expiry cycle is accepted
    applyStimulus(1'b1, 8'hC1);
    idle(TMO - 1);
    applyStimulus(1'b1, 8'hC2);
    checkValue("expiry_no_err", 32'(err_m), 32'd0);
    sendSpaced(8'hC3);
    applyStimulus(1'b1, 8'hC4);
    checkValue("expiry_frame_word", data_m, 32'hC1C2C3C4);
    idle(5);

    // Back-to-back frames
    sendSpaced(8'h11);
    sendSpaced(8'h22);
    sendSpaced(8'h33);
    applyStimulus(1'b1, 8'h44);
    checkValue("b2b_word1", data_m, 32'h11223344);
    sendSpaced(8'h55);
    sendSpaced(8'h66);
    sendSpaced(8'h77);
    applyStimulus(1'b1, 8'h88);
    checkValue("b2b_word2", data_m, 32'h55667788);
    idle(5);

    // Reset mid-frame
    sendSpaced(8'h99);
    sendSpaced(8'h98);
    sendSpaced(8'h97);
    doReset();
    checkValue("reset_data_zero", data_m, 32'h0);
    idle(2);
    sendSpaced(8'hDE);
    sendSpaced(8'hAD);
    sendSpaced(8'hBE);
    applyStimulus(1'b1, 8'hEF);
    checkValue("post_reset_word", data_m, 32'hDEADBEEF);
    checkValue("post_reset_word_lsb", data_l, 32'hEFBEADDE);
    idle(3);

    // Randomised traffic with occasional long silences
    for (int i = 0; i < 600; i++) begin
      logic d;
      logic [7:0] x;
      if (i % 150 == 75) idle(TMO + $urandom_range(0, 10) - 5);
      d = ($urandom_range(0, 9) == 0);
      x = 8'($urandom_range(0, 255));
      applyStimulus(d, x);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multi_byte_rx.md
Name: multi_byte_rx

Overview:
- Receive-side counterpart of the multi-byte UART transmit sequencer.
- Collects consecutive bytes from the single-byte UART receiver into one DATA_WIDTH-bit word, then emits a one-cycle completion pulse.
- Sits between the byte-level UART RX core and the user logic.
- An inter-byte timeout discards partial frames, so a lost byte cannot shift all later words out of alignment.

Parameters:
- DATA_WIDTH, 32: output word width; must be a multiple of 8 and at least 16. NBYTES = DATA_WIDTH/8.
- MSB_1st, 1: 1 = first received byte is the most significant byte; 0 = first received byte is the least significant byte.
- TIMEOUT_CYCLES, 100000: maximum clk cycles allowed between consecutive rx_done pulses inside a frame; must be at least 2.

Ports:
- clk  input  1  system clock, rising edge.
- rstn  input  1  asynchronous active-low reset.
- rx_done  input  1  one-cycle pulse from the byte receiver; rx_data is valid in the same cycle.
- rx_data  input  8  received byte.
- multi_byte_data_out  output  DATA_WIDTH  last completely assembled word.
- multi_byte_rx_done  output  1  one-cycle pulse; the new word is valid on multi_byte_data_out.
- rx_timeout_err  output  1  one-cycle pulse; a partial frame was discarded.
- busy  output  1  high while a frame is partially collected.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rstn.
- Reset values:
  - multi_byte_data_out = 0, multi_byte_rx_done = 0, rx_timeout_err = 0, busy = 0.
  - Internal shift register = 0, byte counter = 0, timeout counter = 0, state = IDLE.
- State IDLE:
  - busy = 0.
  - On rx_done: shift rx_data in, set byte counter to 1, clear timeout counter, go to COLLECT.
- State COLLECT:
  - busy = 1.
  - The timeout counter increments every cycle without rx_done.
  - On rx_done with byte counter < NBYTES-1: shift the byte in, increment the counter, clear the timeout counter, stay in COLLECT.
  - On rx_done with byte counter = NBYTES-1 (last byte), at the same clock edge:
    - multi_byte_data_out <= the completed word, including this byte;
    - multi_byte_rx_done <= 1 for exactly one cycle;
    - byte counter <= 0;
    - go to IDLE.
  - Latency: the done pulse and the new data appear in the cycle immediately after the cycle in which the last rx_done was sampled.
  - Timeout: if the timeout counter reaches TIMEOUT_CYCLES-1 and rx_done is low in that cycle:
    - rx_timeout_err <= 1 for one cycle;
    - shift register and byte counter cleared;
    - go to IDLE;
    - multi_byte_data_out unchanged.
- Shift rules:
  - MSB_1st = 1: reg <= {reg[DATA_WIDTH-9:0], rx_data}.
  - MSB_1st = 0: reg <= {rx_data, reg[DATA_WIDTH-1:8]}.
  - After NBYTES shifts the word is fully aligned; no post-processing is applied.
- Simultaneous events and boundaries:
  - rx_done in the same cycle as timeout expiry: the byte is accepted and no error is raised.
  - rx_done in the cycle directly after a done pulse or an error pulse: accepted as byte 0 of a new frame, since the block is already in IDLE.
- multi_byte_data_out changes only on frame completion and holds its value otherwise, including across timeouts.
- multi_byte_rx_done and rx_timeout_err are never high in the same cycle.
- Reset asserted mid-frame: everything returns immediately to its reset value and the partial frame is lost. The first rx_done after release starts a new frame.
- Counter widths:
  - byte counter: $clog2(NBYTES)+1 bits;
  - timeout counter: $clog2(TIMEOUT_CYCLES) bits, saturating (no wrap).

Test Plan:
- Bench settings: DATA_WIDTH=32, TIMEOUT_CYCLES=50, rx_done pulses 10 cycles apart unless stated.
- MSB_1st=1, bytes 0x12,0x34,0x56,0x78 -> multi_byte_data_out=0x12345678 one cycle after the 4th rx_done; done pulse exactly 1 cycle wide; busy high from after byte 1 until done.
- MSB_1st=0, same bytes -> 0x78563412.
- Bytes 0xAA,0xBB then silence -> rx_timeout_err pulse 50 cycles after the 0xBB rx_done (±1); data_out keeps its previous value; a following 0x01,0x02,0x03,0x04 -> 0x01020304.
- Byte 2 arriving exactly in the timeout-expiry cycle -> no error; the frame completes normally.
- Two frames back-to-back, byte 0 of frame 2 one cycle after the done pulse -> two done pulses with the correct words 0x11223344 and 0x55667788.
- rstn asserted after 3 bytes -> outputs 0 immediately; the next 4 bytes 0xDE,0xAD,0xBE,0xEF -> 0xDEADBEEF; no stale byte from before the reset appears in the word.
